// File: rtl/vx_axi_mem_responder_if.sv
// AXI4 memory-port bundle between a master (e.g. Vortex m_axi_mem_*) and the memory responder.
// Lock, cache, prot and qos are deliberately absent; the responder has no use for them.
interface vx_axi_mem_responder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [ID_WIDTH-1:0]     rid;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/vx_axi_mem_responder.sv
// AXI4 slave memory responder: serves INCR bursts from an internal word-addressed RAM,
// with independent read and write FSMs and one outstanding burst per direction.
module vx_axi_mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 32,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_axi_mem_responder_if.slave s_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
  localparam logic [2:0] FULL_SIZE   = 3'(OFFS);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  w_state_e                  w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]       w_id_q;
  logic [MEM_WORDS_LOG2-1:0] w_idx_q;
  logic [7:0]                w_len_q;
  logic [8:0]                w_beat_q;
  logic                      w_legal_q;
  logic [1:0]                bresp_q;

  r_state_e                  r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]       r_id_q;
  logic [MEM_WORDS_LOG2-1:0] r_idx_q;
  logic [7:0]                r_len_q;
  logic [7:0]                r_beat_q;
  logic                      r_legal_q;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic ram_we, ram_re, r_last;
  logic [DATA_WIDTH-1:0] ram_rd;

  assign aw_fire = s_axi.awvalid & s_axi.awready;
  assign w_fire  = s_axi.wvalid  & s_axi.wready;
  assign b_fire  = s_axi.bvalid  & s_axi.bready;
  assign ar_fire = s_axi.arvalid & s_axi.arready;
  assign r_fire  = s_axi.rvalid  & s_axi.rready;

  // Beats beyond awlen, and every beat of an illegal burst, are accepted but never committed.
  assign ram_we = w_fire & w_legal_q & (w_beat_q <= {1'b0, w_len_q});
  assign ram_re = (r_state_q == R_FETCH);
  assign r_last = (r_beat_q == r_len_q);

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_legal_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_fire) begin
        w_id_q    <= s_axi.awid;
        w_idx_q   <= s_axi.awaddr[OFFS +: MEM_WORDS_LOG2];
        w_len_q   <= s_axi.awlen;
        w_beat_q  <= '0;
        w_legal_q <= (s_axi.awburst == BURST_INCR) && (s_axi.awsize == FULL_SIZE);
      end
      if (w_fire) begin
        // Saturate at 256 so an overlong burst can never alias back onto awlen.
        if (!w_beat_q[8]) w_beat_q <= w_beat_q + 9'd1;
        w_idx_q <= w_idx_q + 1'b1;
        if (s_axi.wlast)
          bresp_q <= (!w_legal_q || (w_beat_q != {1'b0, w_len_q})) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_fire) w_state_d = W_DATA;
      W_DATA:  if (w_fire && s_axi.wlast) w_state_d = W_RESP;
      W_RESP:  if (b_fire) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = (w_state_q == W_IDLE);
    s_axi.wready  = (w_state_q == W_DATA);
    s_axi.bvalid  = (w_state_q == W_RESP);
    s_axi.bid     = w_id_q;
    s_axi.bresp   = bresp_q;
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_legal_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_fire) begin
        r_id_q    <= s_axi.arid;
        r_idx_q   <= s_axi.araddr[OFFS +: MEM_WORDS_LOG2];
        r_len_q   <= s_axi.arlen;
        r_beat_q  <= '0;
        r_legal_q <= (s_axi.arburst == BURST_INCR) && (s_axi.arsize == FULL_SIZE);
      end else if (r_fire && !r_last) begin
        r_idx_q  <= r_idx_q + 1'b1;
        r_beat_q <= r_beat_q + 8'd1;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (r_fire) r_state_d = r_last ? R_IDLE : R_FETCH;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (r_state_q == R_IDLE);
    s_axi.rvalid  = (r_state_q == R_DATA);
    s_axi.rlast   = (r_state_q == R_DATA) && r_last;
    s_axi.rid     = r_id_q;
    s_axi.rresp   = ((r_state_q == R_DATA) && !r_legal_q) ? RESP_SLVERR : RESP_OKAY;
    s_axi.rdata   = ((r_state_q == R_DATA) && r_legal_q) ? ram_rd : '0;
  end

  // ---------------- RAM: one byte-wide read-first block per strobe lane ----------------
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (ram_we && s_axi.wstrb[gi]) lane_mem[w_idx_q] <= s_axi.wdata[gi*8 +: 8];
      if (ram_re) lane_rd_q <= lane_mem[r_idx_q];
    end

    assign ram_rd[gi*8 +: 8] = lane_rd_q;
  end
endmodule

// File: tb/tb_vx_axi_mem_responder.sv
// Directed plus randomized bursts against a byte-level memory model of the responder.
module tb_vx_axi_mem_responder;
  localparam int DW    = 512;
  localparam int SB    = DW / 8;
  localparam int ML    = 6;
  localparam int DEPTH = 1 << ML;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_axi_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(32)) axi ();

  vx_axi_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(32), .MEM_WORDS_LOG2(ML)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_axi (axi)
  );

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wd [16];
  logic [SB-1:0] ws [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [31:0] id, input int lastbeat);
    int cnt;
    bit legal;
    int idx0;
    logic [1:0] exp_resp;
    legal = (burst == 2'b01) && (size == 3'd6);
    idx0  = int'((addr >> 6) & (DEPTH - 1));
    @(negedge clk);
    chk("w_idle_no_wready", axi.wready, 0);
    axi.awvalid = 1'b1; axi.awaddr = addr; axi.awlen = 8'(len);
    axi.awburst = burst; axi.awsize = size; axi.awid = id;
    cnt = 0;
    while (!axi.awready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("aw_accept", cnt < 50, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    chk("aw_busy", axi.awready, 0);
    for (int i = 0; i <= lastbeat; i++) begin
      axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == lastbeat);
      cnt = 0;
      while (!axi.wready && cnt < 50) begin @(negedge clk); cnt++; end
      chk("w_accept", cnt < 50, 1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
    chk("b_latency", axi.bvalid, 1);
    cnt = 0;
    while (!axi.bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    exp_resp = (!legal || lastbeat != len) ? 2'b10 : 2'b00;
    chk("bid", axi.bid, id);
    chk("bresp", axi.bresp, exp_resp);
    @(negedge clk);
    axi.bready = 1'b0;
    chk("b_done_awready", axi.awready, 1);
    chk("b_done_bvalid", axi.bvalid, 0);
    for (int i = 0; i <= lastbeat; i++)
      if (legal && i <= len)
        for (int b = 0; b < SB; b++)
          if (ws[i][b]) model[(idx0 + i) % DEPTH][b*8 +: 8] = wd[i][b*8 +: 8];
    $display("WRITE addr=%08h len=%0d burst=%0d size=%0d id=%0h lastbeat=%0d bresp=%0d",
             addr, len, burst, size, id, lastbeat, exp_resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [31:0] id, input int stall_beat);
    int cnt;
    bit legal;
    int idx0;
    logic [DW-1:0] exp;
    legal = (burst == 2'b01) && (size == 3'd6);
    idx0  = int'((addr >> 6) & (DEPTH - 1));
    @(negedge clk);
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arlen = 8'(len);
    axi.arburst = burst; axi.arsize = size; axi.arid = id;
    cnt = 0;
    while (!axi.arready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("ar_accept", cnt < 50, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk("r_fetch_no_rvalid", axi.rvalid, 0);
    chk("ar_busy", axi.arready, 0);
    @(negedge clk);
    chk("r_first_latency", axi.rvalid, 1);
    for (int i = 0; i <= len; i++) begin
      cnt = 0;
      while (!axi.rvalid && cnt < 50) begin @(negedge clk); cnt++; end
      chk("r_valid", axi.rvalid, 1);
      exp = legal ? model[(idx0 + i) % DEPTH] : '0;
      chk("rdata", axi.rdata, exp);
      chk("rresp", axi.rresp, legal ? 2'b00 : 2'b10);
      chk("rlast", axi.rlast, (i == len));
      chk("rid", axi.rid, id);
      if (i == stall_beat) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_rvalid", axi.rvalid, 1);
          chk("stall_rdata", axi.rdata, exp);
          chk("stall_rlast", axi.rlast, (i == len));
        end
      end
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
    end
    chk("r_done_arready", axi.arready, 1);
    $display("READ  addr=%08h len=%0d burst=%0d size=%0d id=%0h stall=%0d",
             addr, len, burst, size, id, stall_beat);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, lastbeat, cnt;
    logic [1:0] burst;
    logic [2:0] size;
    logic [31:0] addr;

    reset = 1'b0;
    axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
    axi.rready = 0;
    repeat (2) @(negedge clk);
    chk("rst_awready", axi.awready, 1);
    chk("rst_arready", axi.arready, 1);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_rlast", axi.rlast, 0);
    chk("rst_bresp", axi.bresp, 0);
    chk("rst_rresp", axi.rresp, 0);
    chk("rst_bid", axi.bid, 0);
    chk("rst_rid", axi.rid, 0);
    chk("rst_rdata", axi.rdata, 0);
    $display("RESET checked");
    reset = 1'b1;

    // Fill the whole RAM so every later read has a defined expectation.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = rand_word(); ws[i] = '1; end
      axi_write(32'(k * 16 * 64), 15, 2'b01, 3'd6, 32'(k), 15);
    end
    axi_read(32'h0, 15, 2'b01, 3'd6, 32'h77, -1);

    for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); ws[i] = '1; end
    axi_write(32'h40, 3, 2'b01, 3'd6, 32'd5, 3);
    axi_read(32'h40, 3, 2'b01, 3'd6, 32'd9, -1);

    wd[0] = '1; ws[0] = '1;
    axi_write(32'(10 * 64), 0, 2'b01, 3'd6, 32'd1, 0);
    wd[0] = rand_word(); ws[0] = 64'hF;
    axi_write(32'(10 * 64 + 5), 0, 2'b01, 3'd6, 32'd2, 0);
    axi_read(32'(10 * 64), 0, 2'b01, 3'd6, 32'd3, -1);
    chk("partial_strobe_high", axi.rdata, 0);  // burst over: rdata idles at zero

    for (int i = 0; i < 4; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(32'(20 * 64), 3, 2'b01, 3'd6, 32'd4, 1);
    axi_read(32'(20 * 64), 3, 2'b01, 3'd6, 32'd4, -1);

    axi_read(32'(5 * 64), 1, 2'b10, 3'd6, 32'hABC, -1);

    for (int i = 0; i < 2; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(32'((DEPTH - 1) * 64), 1, 2'b01, 3'd6, 32'd6, 1);
    axi_read(32'((DEPTH - 1) * 64), 1, 2'b01, 3'd6, 32'd7, -1);

    axi_read(32'h0, 3, 2'b01, 3'd6, 32'd8, 1);

    for (int t = 0; t < 25; t++) begin
      len      = $urandom_range(0, 7);
      lastbeat = len + int'($urandom_range(0, 2)) - 1;
      if (lastbeat < 0) lastbeat = 0;
      burst = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd6;
      addr  = $urandom;
      for (int i = 0; i < 16; i++) begin wd[i] = rand_word(); ws[i] = {$urandom, $urandom}; end
      axi_write(addr, len, burst, size, $urandom, lastbeat);
      burst = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      axi_read(addr, $urandom_range(0, 7), burst, 3'd6, $urandom,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Abort a write burst with reset after two committed beats.
    @(negedge clk);
    axi.awvalid = 1'b1; axi.awaddr = 32'(30 * 64); axi.awlen = 8'd3;
    axi.awburst = 2'b01; axi.awsize = 3'd6; axi.awid = 32'h55;
    cnt = 0;
    while (!axi.awready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("abort_aw_accept", cnt < 50, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wd[i] = rand_word();
      axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = '1; axi.wlast = 1'b0;
      cnt = 0;
      while (!axi.wready && cnt < 50) begin @(negedge clk); cnt++; end
      chk("abort_w_accept", cnt < 50, 1);
      @(negedge clk);
      model[30 + i] = wd[i];
    end
    axi.wvalid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_bvalid", axi.bvalid, 0);
    chk("abort_awready", axi.awready, 1);
    chk("abort_wready", axi.wready, 0);
    $display("RESET mid-write burst");
    @(negedge clk);
    reset = 1'b1;
    wd[0] = rand_word(); ws[0] = '1;
    axi_write(32'(32 * 64), 0, 2'b01, 3'd6, 32'h66, 0);
    axi_read(32'(30 * 64), 3, 2'b01, 3'd6, 32'h67, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
